key_sched_ctrl: RTL and testbench
=================================

Name: key_sched_ctrl

Overview:
Controller for the AES-128 round-key register file. On start it runs key expansion one round per cycle and writes round keys 0..NUM_ROUNDS into the key register through its write port (iter_in/key_out/key_reg_load). It then sequences the read index (iter_out) for the round datapath, in ascending order for encrypt or descending order for decrypt. It sits between the top-level control FSM and the key register.

Parameters:
KEY_W, 128, round-key width in bits (AES-128 only)
ITER_W, 4, round-index width
NUM_ROUNDS, 10, last round index; legal range 1..10 (bounded by the rcon table)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  pulse: begin expansion of cipher_key; honoured only when not busy
cipher_key  in  KEY_W  cipher key, sampled in the start cycle
decrypt  in  1  order select, sampled with blk_start (1 = descending)
blk_start  in  1  pulse: begin read sequencing for one block
round_adv  in  1  pulse: step iter_out to the next round
iter_in  out  ITER_W  key register write index
key_out  out  KEY_W  key register write data
key_reg_load  out  1  key register write enable
iter_out  out  ITER_W  key register read index
busy  out  1  expansion in progress
keys_ready  out  1  all round keys written and valid
last_round  out  1  iter_out is at the final index of the current order

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While rst is high, all outputs are 0 and the FSM goes to IDLE.
- Write-side outputs (iter_in, key_out, key_reg_load) are registered.
- FSM states: IDLE, EXPAND, READY.
- IDLE:
  - busy=0, keys_ready=0, iter_out=0.
  - start=1 at edge k: register cur_key<=cipher_key, cnt<=0, go to EXPAND.
- EXPAND:
  - Each cycle drive key_reg_load=1, iter_in=cnt, key_out=cur_key.
  - Update cur_key<=aes_key_round(cur_key, rcon[cnt+1]) and cnt++.
  - Exit to READY after the write with cnt==NUM_ROUNDS.
  - Timing: key_reg_load is high for cycles k+1..k+NUM_ROUNDS+1 (11 writes at the default). busy is high over the same window. keys_ready=1 from cycle k+NUM_ROUNDS+2.
- rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36, placed in the MSB byte of the rotated/substituted word.
- READY:
  - keys_ready=1.
  - blk_start: iter_out<=0 (encrypt) or NUM_ROUNDS (decrypt). The order is latched until the next blk_start.
  - round_adv: iter_out +1 (encrypt) or -1 (decrypt). It saturates at the final index and never wraps.
  - last_round is combinational: iter_out equals the final index and a block is active.
  - blk_start and round_adv in the same cycle: blk_start wins.
- Boundary cases:
  - start during EXPAND: ignored, no error.
  - start in READY: immediate re-expansion. keys_ready and last_round drop next cycle, iter_out<=0.
  - blk_start or round_adv outside READY: ignored.
  - rst mid-EXPAND: key_reg_load=0 from the next cycle. Partially written register contents are stale; keys_ready stays 0 until a full expansion completes.
- All arithmetic on cnt and iter_out is unsigned ITER_W. No overflow is possible within 0..NUM_ROUNDS.

Optional Feature:
KEY_SCHED_DEC_EN
- Defined: decrypt is honoured and descending read order is supported.
- Undefined: decrypt is ignored (tie-off tolerated) and the order is always ascending. Decrement logic and the order latch are removed.

Decomposition:
- Package aes_pkg holds:
  - KEY_W, ITER_W, NUM_ROUNDS
  - rcon table as a localparam array
  - state enum (IDLE/EXPAND/READY)
- One combinational sub-module, aes_key_round (cur_key, rcon → next_key):
  - RotWord and SubWord on word 3 using an S-box function
  - rcon XOR
  - chained XOR for words 0..3

Test Plan:
1. Reset: rst=1 for 2 cycles, then release → all outputs 0, FSM IDLE, keys_ready=0.
2. Expansion with FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
   - 11 consecutive key_reg_load cycles.
   - iter_in=0 data equals the cipher key.
   - iter_in=1 data = a0fafe1788542cb123a339392a6c7605.
   - iter_in=10 data = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - keys_ready rises the cycle after the last write.
3. Encrypt order: blk_start with decrypt=0, then 12 round_adv pulses → iter_out goes 0..10 and holds at 10. last_round=1 only at 10.
4. Decrypt order (KEY_SCHED_DEC_EN defined): blk_start with decrypt=1 → iter_out=10. Then 10 round_adv pulses → 9..0. last_round=1 at 0. A further round_adv holds at 0.
5. Protocol corners:
   - start during EXPAND → write sequence unchanged.
   - blk_start and round_adv in the same cycle → iter_out = start index.
   - round_adv before keys_ready → ignored.
6. Abort and restart:
   - rst asserted at write 5 → key_reg_load=0 next cycle, keys_ready=0.
   - New start with key 000102030405060708090a0b0c0d0e0f → round-10 key 13111d7fe3944a17f307a78b4d2b30c5.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants: widths, round count, rcon and S-box tables, FSM encodings.
// Pure declarations; no logic state.
package aes_pkg;

    localparam int KEY_W      = 128;
    localparam int ITER_W     = 4;
    localparam int NUM_ROUNDS = 10;

    localparam logic [ITER_W-1:0] LAST_IDX = ITER_W'(NUM_ROUNDS);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_EXPAND = 2'd1;
    localparam state_t ST_READY  = 2'd2;

    // Index 0 and 11..15 are never consumed by a real round; kept zero so any index is safe.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon_of(input logic [ITER_W-1:0] r);
        return RCON[r];
    endfunction

endpackage

// File: rtl/key_sched_ctrl_if.sv
// Bundle between the control FSM / key register file and the key schedule controller.
// master = control side, slave = key_sched_ctrl.
interface key_sched_ctrl_if;
    import aes_pkg::*;

    logic              start;
    logic [KEY_W-1:0]  cipher_key;
    logic              decrypt;
    logic              blk_start;
    logic              round_adv;
    logic [ITER_W-1:0] iter_in;
    logic [KEY_W-1:0]  key_out;
    logic              key_reg_load;
    logic [ITER_W-1:0] iter_out;
    logic              busy;
    logic              keys_ready;
    logic              last_round;

    modport master (
        output start, cipher_key, decrypt, blk_start, round_adv,
        input  iter_in, key_out, key_reg_load, iter_out, busy, keys_ready, last_round
    );

    modport slave (
        input  start, cipher_key, decrypt, blk_start, round_adv,
        output iter_in, key_out, key_reg_load, iter_out, busy, keys_ready, last_round
    );

endinterface

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: next round key from current round key and rcon byte.
// Latency: combinational. Backpressure: none.
module aes_key_round
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] cur_key,
    input  logic [7:0]       rcon,
    output logic [KEY_W-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, tmp_w;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = cur_key;

    assign rot_w = {w3[23:0], w3[31:24]};
    assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    assign tmp_w = sub_w ^ {rcon, 24'h000000};

    assign n0 = w0 ^ tmp_w;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 round-key controller: expands cipher_key into the key register, then sequences read indices.
// Latency: first write 1 cycle after start, one round key per cycle; keys_ready the cycle after the last write.
// Backpressure: none; start ignored while busy. KEY_SCHED_DEC_EN enables descending (decrypt) read order.
module key_sched_ctrl
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    key_sched_ctrl_if.slave ks
);

    state_t            state;
    logic [ITER_W-1:0] cnt;
    logic [KEY_W-1:0]  cur_key;
    logic [KEY_W-1:0]  nxt_key;
    logic [7:0]        rcon_nxt;
    logic              load_q;
    logic [ITER_W-1:0] iter_rd;
    logic              blk_act;
    logic [ITER_W-1:0] start_idx;
    logic [ITER_W-1:0] final_idx;
    logic [ITER_W-1:0] adv_idx;

    // cur_key always holds the key presented on the write port; the round step runs one ahead.
    assign rcon_nxt = rcon_of(cnt + ITER_W'(1));

    aes_key_round u_key_round (
        .cur_key  (cur_key),
        .rcon     (rcon_nxt),
        .next_key (nxt_key)
    );

`ifdef KEY_SCHED_DEC_EN
    logic dec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= 1'b0;
        end else if (state == ST_READY && !ks.start && ks.blk_start) begin
            dec_q <= ks.decrypt;
        end
    end

    assign start_idx = ks.decrypt ? LAST_IDX : '0;
    assign final_idx = dec_q ? '0 : LAST_IDX;
    assign adv_idx   = dec_q ? (iter_rd - ITER_W'(1)) : (iter_rd + ITER_W'(1));
`else
    logic unused_dec;
    assign unused_dec = ks.decrypt;

    assign start_idx = '0;
    assign final_idx = LAST_IDX;
    assign adv_idx   = iter_rd + ITER_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur_key <= '0;
            load_q  <= 1'b0;
            iter_rd <= '0;
            blk_act <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ks.start) begin
                        state   <= ST_EXPAND;
                        cur_key <= ks.cipher_key;
                        cnt     <= '0;
                        load_q  <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    if (cnt == LAST_IDX) begin
                        state  <= ST_READY;
                        load_q <= 1'b0;
                    end else begin
                        cur_key <= nxt_key;
                        cnt     <= cnt + ITER_W'(1);
                    end
                end
                ST_READY: begin
                    // Re-expansion invalidates any block in flight.
                    if (ks.start) begin
                        state   <= ST_EXPAND;
                        cur_key <= ks.cipher_key;
                        cnt     <= '0;
                        load_q  <= 1'b1;
                        iter_rd <= '0;
                        blk_act <= 1'b0;
                    end else if (ks.blk_start) begin
                        iter_rd <= start_idx;
                        blk_act <= 1'b1;
                    end else if (ks.round_adv && blk_act && (iter_rd != final_idx)) begin
                        iter_rd <= adv_idx;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ks.iter_in      = cnt;
    assign ks.key_out      = cur_key;
    assign ks.key_reg_load = load_q;
    assign ks.iter_out     = iter_rd;
    assign ks.busy         = !rst && (state == ST_EXPAND);
    assign ks.keys_ready   = !rst && (state == ST_READY);
    assign ks.last_round   = !rst && blk_act && (iter_rd == final_idx);

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: write-port scoreboard fed by an independent GF(2^8) key-expansion model,
// plus directed read-order and protocol-corner checks.
module tb_key_sched_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] KEY1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY1_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY2    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_sched_ctrl_if ks ();

    key_sched_ctrl dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } wr_t;

    wr_t          wr_q[$];
    logic [127:0] wr_log [0:15];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: S-box from GF(2^8) inversion + affine map, rcon by repeated doubling.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] e;
        p = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            p = gmul(p, p);
            if (e[i]) p = gmul(p, x);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] m_round(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, rot, t, n0, n1, n2, n3;
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {m_sbox(rot[31:24]), m_sbox(rot[23:16]), m_sbox(rot[15:8]), m_sbox(rot[7:0])} ^ {rc, 24'h0};
        n0  = k[127:96] ^ t;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic push_expect(input logic [127:0] key);
        logic [127:0] k;
        logic [7:0]   rc;
        wr_t          e;
        k  = key;
        rc = 8'h01;
        for (int r = 0; r <= NR; r++) begin
            e.idx = 4'(r);
            e.key = k;
            wr_q.push_back(e);
            k  = m_round(k, rc);
            rc = gmul(rc, 8'h02);
        end
    endtask

    // Write-port monitor: every key_reg_load cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ks.key_reg_load === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("wr_extra", 128'(ks.key_reg_load), 128'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_idx", 128'(ks.iter_in), 128'(e.idx));
                chk("wr_key", ks.key_out, e.key);
                wr_log[ks.iter_in] = ks.key_out;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ks.start     = 1'b0;
        ks.blk_start = 1'b0;
        ks.round_adv = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_iter_in"}, 128'(ks.iter_in), 128'd0);
        chk({tag, "_key_out"}, ks.key_out, 128'd0);
        chk({tag, "_load"}, 128'(ks.key_reg_load), 128'd0);
        chk({tag, "_iter_out"}, 128'(ks.iter_out), 128'd0);
        chk({tag, "_busy"}, 128'(ks.busy), 128'd0);
        chk({tag, "_rdy"}, 128'(ks.keys_ready), 128'd0);
        chk({tag, "_last"}, 128'(ks.last_round), 128'd0);
    endtask

    task automatic run_expand(input logic [127:0] key, input bit inject);
        push_expect(key);
        ks.start      = 1'b1;
        ks.cipher_key = key;
        tick();
        clr_in();
        ks.cipher_key = ~key;
        for (int c = 0; c <= NR; c++) begin
            if (inject && c == 4) begin
                ks.start      = 1'b1;
                ks.cipher_key = 128'hdeadbeef_00000000_cafef00d_12345678;
                ks.blk_start  = 1'b1;
                ks.round_adv  = 1'b1;
            end
            @(negedge clk);
            chk("exp_busy", 128'(ks.busy), 128'd1);
            chk("exp_rdy", 128'(ks.keys_ready), 128'd0);
            chk("exp_iter_out", 128'(ks.iter_out), 128'd0);
            chk("exp_last", 128'(ks.last_round), 128'd0);
            tick();
            clr_in();
        end
        @(negedge clk);
        chk("rdy_rise", 128'(ks.keys_ready), 128'd1);
        chk("busy_fall", 128'(ks.busy), 128'd0);
        chk("load_fall", 128'(ks.key_reg_load), 128'd0);
        chk("sb_empty", 128'(wr_q.size()), 128'd0);
    endtask

    task automatic pulse_adv(input logic [3:0] exp_idx, input bit exp_last, input string tag);
        ks.round_adv = 1'b1;
        tick();
        clr_in();
        @(negedge clk);
        chk({tag, "_idx"}, 128'(ks.iter_out), 128'(exp_idx));
        chk({tag, "_last"}, 128'(ks.last_round), 128'(exp_last));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int exp_idx;
        rst = 1'b1;
        ks.start = 1'b0; ks.blk_start = 1'b0; ks.round_adv = 1'b0;
        ks.decrypt = 1'b0; ks.cipher_key = '0;
        tick();
        tick();
        @(negedge clk);
        chk_idle("rst");
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk_idle("idle");

        // Read-side controls before any keys exist are ignored.
        ks.blk_start = 1'b1; ks.round_adv = 1'b1;
        tick();
        clr_in();
        @(negedge clk);
        chk_idle("early_blk");

        // FIPS-197 key with a stray start/blk_start/round_adv mid-expansion.
        run_expand(KEY1, 1'b1);
        chk("k0", wr_log[0], KEY1);
        chk("k1", wr_log[1], KEY1_R1);
        chk("k10", wr_log[10], KEY1_RA);

        // Encrypt order; blk_start beats a simultaneous round_adv.
        ks.decrypt = 1'b0; ks.blk_start = 1'b1;
        tick();
        clr_in();
        @(negedge clk);
        chk("enc_start_idx", 128'(ks.iter_out), 128'd0);
        chk("enc_start_last", 128'(ks.last_round), 128'd0);
        for (int i = 1; i <= 3; i++) pulse_adv(4'(i), 1'b0, "enc_pre");
        ks.blk_start = 1'b1; ks.round_adv = 1'b1;
        tick();
        clr_in();
        @(negedge clk);
        chk("both_idx", 128'(ks.iter_out), 128'd0);
        exp_idx = 0;
        for (int i = 0; i < 12; i++) begin
            if (exp_idx < NR) exp_idx++;
            pulse_adv(4'(exp_idx), exp_idx == NR, "enc");
        end

`ifdef KEY_SCHED_DEC_EN
        ks.decrypt = 1'b1; ks.blk_start = 1'b1;
        tick();
        clr_in();
        ks.decrypt = 1'b0;
        @(negedge clk);
        chk("dec_start_idx", 128'(ks.iter_out), 128'd10);
        chk("dec_start_last", 128'(ks.last_round), 128'd0);
        exp_idx = NR;
        for (int i = 0; i < 11; i++) begin
            if (exp_idx > 0) exp_idx--;
            pulse_adv(4'(exp_idx), exp_idx == 0, "dec");
        end
`else
        ks.decrypt = 1'b1; ks.blk_start = 1'b1;
        tick();
        clr_in();
        @(negedge clk);
        chk("dec_off_idx", 128'(ks.iter_out), 128'd0);
        pulse_adv(4'd1, 1'b0, "dec_off");
        for (int i = 2; i <= NR; i++) pulse_adv(4'(i), i == NR, "dec_off_run");
        ks.decrypt = 1'b0;
`endif
        chk("pre_restart_last", 128'(ks.last_round), 128'd1);

        // Start from READY re-expands at once.
        run_expand(KEY1, 1'b0);
        chk("re_k10", wr_log[10], KEY1_RA);

        // Abort with reset during write 5.
        push_expect(KEY1);
        ks.start = 1'b1; ks.cipher_key = KEY1;
        tick();
        clr_in();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_iter", 128'(ks.iter_in), 128'd5);
        tick();
        rst = 1'b0;
        wr_q.delete();
        @(negedge clk);
        chk("abort_load", 128'(ks.key_reg_load), 128'd0);
        chk("abort_rdy", 128'(ks.keys_ready), 128'd0);
        chk("abort_busy", 128'(ks.busy), 128'd0);
        tick();
        @(negedge clk);
        chk("abort_rdy2", 128'(ks.keys_ready), 128'd0);

        run_expand(KEY2, 1'b0);
        chk("k2_0", wr_log[0], KEY2);
        chk("k2_10", wr_log[10], KEY2_RA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
